// File: rtl/relu_maxpool2x2.sv
// relu_maxpool2x2: ReLU then 2x2 stride-2 max-pool over a raster conv stream, dropping warm-up samples
module relu_maxpool2x2 #(
  parameter int IMG_W = 26,
  parameter int IMG_H = 26,
  parameter int SKIP  = 2,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          num_block_change,
  input  logic          in_valid,
  input  logic [DW-1:0] in_pix,
  output logic          out_valid,
  output logic [DW-1:0] out_pix,
  output logic          out_row_last,
  output logic          frame_done
);
  localparam int HW = IMG_W / 2;
  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam int SW = SKIP > 0 ? $clog2(SKIP + 1) : 1;
  localparam int AW = HW > 1 ? $clog2(HW) : 1;
  localparam logic [1:0] WARM = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] INIT = SKIP == 0 ? RUN : WARM;
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_END   = CW'(2 * HW);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_END   = RW'(2 * (IMG_H / 2));
  localparam logic [RW-1:0] ROW_PLAST = RW'(2 * (IMG_H / 2) - 1);
  localparam logic [AW-1:0] PAIR_LAST = AW'(HW - 1);
  localparam logic [SW-1:0] SKIP_LAST = SW'(SKIP > 0 ? SKIP - 1 : 0);
  logic [1:0]    state;
  logic [SW-1:0] skip_cnt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DW-1:0] h_reg, r, hmax, lb, res;
  logic [DW-1:0] line_buf [HW];
  logic [AW-1:0] idx;
  logic          acc, in_win, last;
  always_comb begin
    acc    = in_valid && state == RUN && !rst && !num_block_change;
    r      = in_pix[DW-1] ? '0 : in_pix;
    idx    = AW'(col >> 1);
    lb     = line_buf[idx];
    hmax   = h_reg > r ? h_reg : r;
    res    = lb > hmax ? lb : hmax;
    in_win = col < COL_END && row < ROW_END;
    last   = col == COL_LAST && row == ROW_LAST;
  end
  always_ff @(posedge clk) begin
    if (rst || num_block_change) begin
      state        <= INIT;
      skip_cnt     <= '0;
      col          <= '0;
      row          <= '0;
      out_valid    <= 1'b0;
      out_pix      <= '0;
      out_row_last <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      out_valid    <= 1'b0;
      out_row_last <= 1'b0;
      frame_done   <= 1'b0;
      if (in_valid && state == WARM) begin
        skip_cnt <= skip_cnt + 1'b1;
        if (skip_cnt == SKIP_LAST) state <= RUN;
      end
      if (acc) begin
        col <= col == COL_LAST ? '0 : col + 1'b1;
        row <= last ? '0 : col == COL_LAST ? row + 1'b1 : row;
        if (last) state <= DONE;
        if (in_win && row[0] && col[0]) begin
          out_valid    <= 1'b1;
          out_pix      <= res;
          out_row_last <= idx == PAIR_LAST;
          frame_done   <= idx == PAIR_LAST && row == ROW_PLAST;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (acc && in_win) begin
      if (!col[0]) h_reg <= r;
      else if (!row[0]) line_buf[idx] <= hmax;
    end
  end
endmodule

// File: tb/tb_relu_maxpool2x2.sv
// tb_relu_maxpool2x2: scoreboard bench for two pooling geometries against a frame-array reference model
module tb_relu_maxpool2x2;
  typedef struct {
    int     pix;
    bit     rl;
    bit     fd;
    longint due;
  } exp_t;
  localparam int W [2] = '{4, 5};
  localparam int H [2] = '{4, 5};
  localparam int SK[2] = '{2, 0};
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nbc[2], vin[2], ov[2], rl[2], fd[2];
  logic [15:0] pin[2], op[2];
  exp_t        q0[$], q1[$];
  int          n_chk = 0, n_fail = 0;
  int          skl[2], cnt[2];
  bit          dn[2];
  int          img[2][25];
  always #5 clk = ~clk;
  relu_maxpool2x2 #(.IMG_W(4), .IMG_H(4), .SKIP(2), .DW(16)) d4 (
    .clk(clk), .rst(rst), .num_block_change(nbc[0]), .in_valid(vin[0]), .in_pix(pin[0]),
    .out_valid(ov[0]), .out_pix(op[0]), .out_row_last(rl[0]), .frame_done(fd[0])
  );
  relu_maxpool2x2 #(.IMG_W(5), .IMG_H(5), .SKIP(0), .DW(16)) d5 (
    .clk(clk), .rst(rst), .num_block_change(nbc[1]), .in_valid(vin[1]), .in_pix(pin[1]),
    .out_valid(ov[1]), .out_pix(op[1]), .out_row_last(rl[1]), .frame_done(fd[1])
  );
  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset(int id);
    skl[id] = SK[id];
    cnt[id] = 0;
    dn[id]  = 1'b0;
  endtask
  task automatic model(int id, bit v, logic [15:0] p, bit b);
    int c, rw, r, m;
    exp_t e;
    if (b) model_reset(id);
    else if (v && !dn[id]) begin
      if (skl[id] > 0) skl[id]--;
      else begin
        r = p[15] ? 0 : int'(p);
        c = cnt[id] % W[id];
        rw = cnt[id] / W[id];
        img[id][cnt[id]] = r;
        if (c % 2 == 1 && rw % 2 == 1 && c < W[id] / 2 * 2 && rw < H[id] / 2 * 2) begin
          m = r;
          if (img[id][cnt[id] - 1] > m) m = img[id][cnt[id] - 1];
          if (img[id][cnt[id] - W[id]] > m) m = img[id][cnt[id] - W[id]];
          if (img[id][cnt[id] - W[id] - 1] > m) m = img[id][cnt[id] - W[id] - 1];
          e.pix = m;
          e.rl  = c == W[id] / 2 * 2 - 1;
          e.fd  = e.rl && rw == H[id] / 2 * 2 - 1;
          e.due = longint'($time) + 10;
          if (id == 0) q0.push_back(e);
          else q1.push_back(e);
        end
        cnt[id]++;
        if (cnt[id] == W[id] * H[id]) dn[id] = 1'b1;
      end
    end
  endtask
  task automatic step(int id, bit v, logic [15:0] p, bit b);
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      vin[j] = 1'b0;
      nbc[j] = 1'b0;
    end
    vin[id] = v;
    pin[id] = p;
    nbc[id] = b;
    model(id, v, p, b);
  endtask
  task automatic idle(int k);
    repeat (k) step(0, 1'b0, 16'h0, 1'b0);
  endtask
  task automatic stream(int id, int warm, int first, int n, int gap);
    for (int i = 0; i < warm; i++) begin
      step(id, 1'b1, 16'h7FFF, 1'b0);
      repeat (gap) step(id, 1'b0, 16'h0, 1'b0);
    end
    for (int i = 0; i < n; i++) begin
      step(id, 1'b1, 16'(first + i), 1'b0);
      repeat (gap) step(id, 1'b0, 16'h0, 1'b0);
    end
  endtask
  task automatic drain();
    idle(3);
    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);
  endtask
  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 2; j++) begin
      vin[j] = 1'b0;
      nbc[j] = 1'b0;
      model_reset(j);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 2; j++) begin
      chk("rst out_valid", int'(ov[j]), 0);
      chk("rst out_pix", int'(op[j]), 0);
      chk("rst out_row_last", int'(rl[j]), 0);
      chk("rst frame_done", int'(fd[j]), 0);
    end
  endtask
  task automatic mon(int id);
    exp_t e;
    if ((id == 0 ? q0.size() : q1.size()) == 0) chk("unexpected out_valid", int'(ov[id]), 0);
    else begin
      e = id == 0 ? q0.pop_front() : q1.pop_front();
      chk("out_pix", int'(op[id]), e.pix);
      chk("out_row_last", int'(rl[id]), int'(e.rl));
      chk("frame_done", int'(fd[id]), int'(e.fd));
      chk("latency", int'(longint'($time) - e.due), 0);
    end
  endtask
  always @(negedge clk) begin
    if (ov[0] === 1'b1) mon(0);
    if (ov[1] === 1'b1) mon(1);
  end
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    logic [15:0] mix[6];
    int n;
    mix = '{16'h8000, 16'h0003, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001};
    for (int j = 0; j < 2; j++) begin
      vin[j] = 1'b0;
      nbc[j] = 1'b0;
      pin[j] = '0;
    end
    do_rst();
    step(0, 1'b0, 16'h0, 1'b1);
    stream(0, 2, 1, 16, 0);
    drain();
    step(0, 1'b0, 16'h0, 1'b1);
    stream(0, 2, 0, 0, 0);
    repeat (16) step(0, 1'b1, 16'hFFFB, 1'b0);
    drain();
    step(0, 1'b0, 16'h0, 1'b1);
    stream(0, 2, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1'b1, mix[i], 1'b0);
    for (int i = 0; i < 10; i++) step(0, 1'b1, 16'($urandom), 1'b0);
    drain();
    step(0, 1'b0, 16'h0, 1'b1);
    stream(0, 2, 1, 16, 2);
    drain();
    step(0, 1'b0, 16'h0, 1'b1);
    stream(0, 2, 1, 9, 0);
    step(0, 1'b1, 16'h1234, 1'b1);
    stream(0, 2, 1, 16, 0);
    drain();
    step(1, 1'b0, 16'h0, 1'b1);
    stream(1, 0, 1, 25, 0);
    stream(1, 0, 100, 5, 0);
    drain();
    step(0, 1'b0, 16'h0, 1'b1);
    stream(0, 2, 1, 6, 0);
    do_rst();
    stream(0, 2, 1, 16, 0);
    drain();
    for (int f = 0; f < 8; f++) begin
      n = SK[f % 2] + W[f % 2] * H[f % 2] + 3;
      step(f % 2, 1'b0, 16'h0, 1'b1);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) step(f % 2, 1'b0, 16'($urandom), 1'b0);
        step(f % 2, 1'b1, 16'($urandom), 1'b0);
      end
      drain();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/relu_maxpool2x2.md
Name: relu_maxpool2x2

Overview:
- Consumes the 16-bit serial output stream of the 3-tap convolution accumulator stage (out_pix) and drops the pipeline warm-up samples after each block change.
- Applies ReLU, then a 2x2 stride-2 max-pool over the raster-ordered feature map using a half-width line buffer.
- Emits one pooled pixel per 2x2 window with row/frame markers for the next layer or the output buffer.

Parameters:
- IMG_W, 26, conv-output pixels per row; odd value: last column dropped.
- IMG_H, 26, conv-output rows per block; odd value: last row dropped.
- SKIP, 2, valid samples discarded after each num_block_change (accumulator warm-up).
- DW, 16, data width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- num_block_change  in  1  start of new block; clears counters and state
- in_valid  in  1  in_pix carries a conv sample this cycle
- in_pix  in  DW  conv sample, two's-complement signed
- out_valid  out  1  pooled pixel valid, single-cycle pulse
- out_pix  out  DW  pooled pixel, always >= 0
- out_row_last  out  1  with out_valid: last pooled pixel of a pooled row
- frame_done  out  1  with out_valid: last pooled pixel of the block

Behaviour:
- Reset (rst=1 at a clock edge) sets out_valid, out_pix, out_row_last and frame_done to 0, state to WARM, and skip/col/row counters to 0. Line buffer contents are don't-care.
- num_block_change has the same effect as rst on state, counters and outputs. It wins over a coincident in_valid; that sample is dropped.
- States:
  - WARM: each in_valid increments skip_cnt. On the SKIP-th valid, go to RUN with the sample discarded. SKIP=0 enters RUN directly.
  - RUN: each in_valid is accepted.
  - DONE: in_valid is ignored until num_block_change or rst.
- ReLU: r = in_pix[DW-1] ? 0 : in_pix. All comparisons are unsigned on r.
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1 advance on each accepted sample; col wraps and row increments at IMG_W-1.
- Samples with col >= 2*(IMG_W/2) or row >= 2*(IMG_H/2) are accepted for counting only.
- Horizontal pair: at even col, hold r in h_reg. At odd col, hmax = max(h_reg, r).
  - Even row: line_buf[col>>1] <= hmax.
  - Odd row: result = max(line_buf[col>>1], hmax).
- Output latency: out_valid rises the cycle after the accepted sample that completes a window (odd row, odd col). It is a single-cycle pulse; out_pix holds its value until the next result.
- out_row_last: asserted with out_valid when col>>1 == IMG_W/2-1.
- frame_done: asserted with out_valid on the final window, i.e. the last window of row 2*(IMG_H/2)-1. Enter DONE when the final counted sample is accepted; trailing dropped rows are still counted.
- Gaps: in_valid may deassert for any number of cycles. All state holds and no output is produced.
- Line buffer: IMG_W/2 entries x DW, single write port and single read port.
- Throughput: one sample per clock sustained, with no backpressure.

Test Plan:
- IMG_W=4, IMG_H=4, SKIP=2: after block change, feed 0x7FFF, 0x7FFF (warm-up) then 1..16 -> outputs 6, 8, 16? No: window values are 6, 8, 14, 16. out_row_last on 8 and 16; frame_done only with 16. No output for the warm-up samples.
- ReLU: same config, all 16 samples = 0xFFFB (-5) -> four outputs of 0x0000. Mixed window {0x8000, 3, 0xFFFF, 1} -> 3.
- Gaps: repeat the 1..16 stream with in_valid toggling 1,0,0,1,... -> identical outputs 6, 8, 14, 16. Each out_valid comes exactly one cycle after the completing sample.
- Mid-frame block change: assert num_block_change together with in_valid after sample 9 -> that sample is dropped, no output. Then feed 2 warm-up samples plus 1..16 -> 6, 8, 14, 16.
- Odd geometry: IMG_W=5, IMG_H=5, SKIP=0, feed 1..25 -> outputs 7, 9, 17, 19 (column 4 and row 4 dropped). frame_done with 19; state DONE; further in_valid produces nothing.
- Reset: assert rst during a frame -> all outputs 0 next cycle. A new stream then behaves like the first scenario.
